// File: rtl/combine_cb_scheduler_pkg.sv
// Shared definitions for the HARQ combine slot sequencer: state encodings,
// credit limits, error-flag bit positions and index widths.
package combine_cb_scheduler_pkg;

    localparam int USER_IDX_W    = 4;
    localparam int CREDIT_W      = 2;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = 2'd2;

    localparam int ERR_TIMEOUT    = 0;
    localparam int ERR_OVERRUN    = 1;
    localparam int ERR_CREDIT_OVF = 2;
    localparam int ERR_W          = 3;

    localparam int DEF_NUM_USERS = 8;
    localparam int DEF_CB_CNT_W  = 6;
    localparam int DEF_TIMEOUT_W = 16;

    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_SCAN      = 6'b000010,
        ST_CREDIT    = 6'b000100,
        ST_REQ       = 6'b001000,
        ST_WAIT_COMP = 6'b010000,
        ST_DONE      = 6'b100000
    } state_e;

endpackage

// File: rtl/combine_cb_scheduler_if.sv
// Slot configuration, combine-engine handshake and status bundle of the
// combine scheduler; the master side drives slot/config/completion pulses.
interface combine_cb_scheduler_if
    import combine_cb_scheduler_pkg::*;
#(
    parameter int NUM_USERS = DEF_NUM_USERS,
    parameter int CB_CNT_W  = DEF_CB_CNT_W
);
    // Handshake: every control here is a 1-cycle pulse, no back-pressure.
    // A request holds its user/CB index until the matching completion pulse;
    // a drain pulse returns one output-buffer credit.
    logic                            i_rdm_slot_start;
    logic [NUM_USERS-1:0]            i_users_valid_mask;
    logic [NUM_USERS*CB_CNT_W-1:0]   i_users_cb_num;
    logic                            o_Combine_process_request;
    logic [USER_IDX_W-1:0]           o_Combine_user_index;
    logic [CB_CNT_W-1:0]             o_Combine_cb_index;
    logic                            i_current_cb_combine_comp;
    logic                            i_SENDHARQ_Data_Comp;
    logic                            o_busy;
    logic                            o_slot_done;
    logic [15:0]                     o_cb_total;
    logic [ERR_W-1:0]                o_err_flags;
    state_e                          o_state_dbg;

    modport master (
        output i_rdm_slot_start, i_users_valid_mask, i_users_cb_num,
               i_current_cb_combine_comp, i_SENDHARQ_Data_Comp,
        input  o_Combine_process_request, o_Combine_user_index, o_Combine_cb_index,
               o_busy, o_slot_done, o_cb_total, o_err_flags, o_state_dbg
    );

    modport slave (
        input  i_rdm_slot_start, i_users_valid_mask, i_users_cb_num,
               i_current_cb_combine_comp, i_SENDHARQ_Data_Comp,
        output o_Combine_process_request, o_Combine_user_index, o_Combine_cb_index,
               o_busy, o_slot_done, o_cb_total, o_err_flags, o_state_dbg
    );

endinterface

// File: rtl/combine_cb_scheduler_credit.sv
// Ping/pong output-buffer credit counter: 0..CREDIT_MAX, simultaneous
// inc/dec cancel, an increment at the limit saturates and pulses ovf_o.
module combine_credit_cnt
    import combine_cb_scheduler_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                ovf_o
);

    logic [CREDIT_W-1:0] credit_q, credit_d;

    always_comb begin
        credit_d = credit_q;
        ovf_o    = 1'b0;
        if (inc_i && !dec_i) begin
            if (credit_q == CREDIT_MAX) begin
                ovf_o = 1'b1;
            end else begin
                credit_d = credit_q + 1'b1;
            end
        end else if (dec_i && !inc_i && credit_q != '0) begin
            credit_d = credit_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_q <= CREDIT_MAX;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit_o = credit_q;

endmodule

// File: rtl/combine_cb_scheduler.sv
// Slot-level HARQ combine sequencer: walks active users and their CBs, issues
// one credit-throttled combine request per CB, and tracks stall/error status.
module combine_cb_scheduler
    import combine_cb_scheduler_pkg::*;
#(
    parameter int NUM_USERS = DEF_NUM_USERS,
    parameter int CB_CNT_W  = DEF_CB_CNT_W,
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
)
(
    input  logic                  i_core_clk,
    input  logic                  i_rx_rstn,
    combine_cb_scheduler_if.slave bus
);

    state_e                        state_q, state_d;
    logic [USER_IDX_W-1:0]         user_ptr_q, user_ptr_d;
    logic [CB_CNT_W-1:0]           cb_ptr_q, cb_ptr_d;
    logic [NUM_USERS-1:0]          mask_q, mask_d;
    logic [NUM_USERS*CB_CNT_W-1:0] cbnum_q, cbnum_d;
    logic [TIMEOUT_W-1:0]          wd_q, wd_d;
    logic [15:0]                   total_q, total_d;
    logic [ERR_W-1:0]              err_q, err_d;

    logic [CREDIT_W-1:0]   credit;
    logic                  credit_ovf;
    logic                  scan_hit;
    logic [USER_IDX_W-1:0] scan_user;
    logic [CB_CNT_W-1:0]   cur_cb_num;
    logic                  comp, last_cb, last_user, wd_expired;

    combine_credit_cnt u_credit (
        .clk_i    (i_core_clk),
        .rst_ni   (i_rx_rstn),
        .inc_i    (bus.i_SENDHARQ_Data_Comp),
        .dec_i    (state_q == ST_REQ),
        .credit_o (credit),
        .ovf_o    (credit_ovf)
    );

    // SCAN resolves the next active user at or after user_ptr in one cycle,
    // so an empty slot reaches DONE on the second cycle after accept.
    always_comb begin
        scan_hit  = 1'b0;
        scan_user = '0;
        for (int u = NUM_USERS - 1; u >= 0; u--) begin
            if (u[USER_IDX_W-1:0] >= user_ptr_q && mask_q[u] &&
                cbnum_q[u*CB_CNT_W +: CB_CNT_W] != '0) begin
                scan_hit  = 1'b1;
                scan_user = u[USER_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        cur_cb_num = '0;
        for (int u = 0; u < NUM_USERS; u++) begin
            if (user_ptr_q == u[USER_IDX_W-1:0]) begin
                cur_cb_num = cbnum_q[u*CB_CNT_W +: CB_CNT_W];
            end
        end
    end

    assign comp       = bus.i_current_cb_combine_comp && (state_q == ST_WAIT_COMP);
    assign last_cb    = (cb_ptr_q == cur_cb_num - 1'b1);
    assign last_user  = (user_ptr_q == USER_IDX_W'(NUM_USERS - 1));
    assign wd_expired = &wd_q;

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (bus.i_rdm_slot_start) state_d = ST_SCAN;
            ST_SCAN:      state_d = scan_hit ? ST_CREDIT : ST_DONE;
            ST_CREDIT:    if (credit != '0) state_d = ST_REQ;
            ST_REQ:       state_d = ST_WAIT_COMP;
            ST_WAIT_COMP: begin
                if (comp) begin
                    if (!last_cb)       state_d = ST_CREDIT;
                    else if (last_user) state_d = ST_DONE;
                    else                state_d = ST_SCAN;
                end else if (wd_expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        user_ptr_d = user_ptr_q;
        cb_ptr_d   = cb_ptr_q;
        mask_d     = mask_q;
        cbnum_d    = cbnum_q;
        wd_d       = wd_q;
        total_d    = total_q;
        err_d      = err_q;

        if (credit_ovf) err_d[ERR_CREDIT_OVF] = 1'b1;
        if (bus.i_rdm_slot_start && state_q != ST_IDLE) err_d[ERR_OVERRUN] = 1'b1;

        case (state_q)
            ST_IDLE: if (bus.i_rdm_slot_start) begin
                mask_d     = bus.i_users_valid_mask;
                cbnum_d    = bus.i_users_cb_num;
                user_ptr_d = '0;
                cb_ptr_d   = '0;
                total_d    = '0;
            end
            ST_SCAN: if (scan_hit) user_ptr_d = scan_user;
            ST_REQ:  wd_d = '0;
            ST_WAIT_COMP: begin
                if (comp) begin
                    if (total_q != 16'hFFFF) total_d = total_q + 1'b1;
                    if (last_cb) begin
                        cb_ptr_d   = '0;
                        user_ptr_d = user_ptr_q + 1'b1;
                    end else begin
                        cb_ptr_d = cb_ptr_q + 1'b1;
                    end
                end else if (wd_expired) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            user_ptr_q <= '0;
            cb_ptr_q   <= '0;
            mask_q     <= '0;
            cbnum_q    <= '0;
            wd_q       <= '0;
            total_q    <= '0;
            err_q      <= '0;
        end else begin
            user_ptr_q <= user_ptr_d;
            cb_ptr_q   <= cb_ptr_d;
            mask_q     <= mask_d;
            cbnum_q    <= cbnum_d;
            wd_q       <= wd_d;
            total_q    <= total_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        bus.o_Combine_process_request = (state_q == ST_REQ);
        bus.o_Combine_user_index      = user_ptr_q;
        bus.o_Combine_cb_index        = cb_ptr_q;
        bus.o_busy                    = (state_q != ST_IDLE);
        bus.o_slot_done               = (state_q == ST_DONE);
        bus.o_cb_total                = total_q;
        bus.o_err_flags               = err_q;
        bus.o_state_dbg               = state_q;
    end

endmodule

// File: tb/tb_combine_cb_scheduler.sv
// Directed bench for combine_cb_scheduler: scoreboard of expected requests,
// combine/drain responder, and slot-level status checks.
module tb_combine_cb_scheduler;
    import combine_cb_scheduler_pkg::*;

    localparam int TO_W     = 10;
    localparam int COMP_DLY = 4;

    logic clk;
    logic rstn;

    combine_cb_scheduler_if #(.NUM_USERS(8), .CB_CNT_W(6)) bus();

    combine_cb_scheduler #(.NUM_USERS(8), .CB_CNT_W(6), .TIMEOUT_W(TO_W)) dut (
        .i_core_clk (clk),
        .i_rx_rstn  (rstn),
        .bus        (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 50000 cycles");
        $fatal(1);
    end

    int n_total = 0;
    int n_pass  = 0;
    int req_cnt = 0;
    logic [9:0] exp_q[$];

    logic comp_en;
    logic auto_drain;
    int   drain_req_cnt  = 0;
    int   drain_done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // scoreboard monitor
    initial begin
        logic [9:0] got;
        logic [9:0] exp;
        forever begin
            @(negedge clk);
            if (rstn && bus.o_Combine_process_request) begin
                req_cnt++;
                got = {bus.o_Combine_user_index, bus.o_Combine_cb_index};
                if (exp_q.size() == 0) begin
                    check("unexpected_request", 32'(got), 32'h3ff);
                end else begin
                    exp = exp_q.pop_front();
                    check("request_index", 32'(got), 32'(exp));
                end
            end
        end
    end

    // combine engine / SENDHARQ responder
    initial begin
        int comp_cnt;
        comp_cnt = 0;
        bus.i_current_cb_combine_comp = 1'b0;
        bus.i_SENDHARQ_Data_Comp      = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_current_cb_combine_comp = 1'b0;
            bus.i_SENDHARQ_Data_Comp      = 1'b0;
            if (!rstn) begin
                comp_cnt = 0;
            end else begin
                if (comp_cnt > 0) begin
                    comp_cnt--;
                    if (comp_cnt == 0) bus.i_current_cb_combine_comp = 1'b1;
                end
                if (bus.o_Combine_process_request) begin
                    if (comp_en) comp_cnt = COMP_DLY;
                    if (auto_drain) bus.i_SENDHARQ_Data_Comp = 1'b1;
                end
                if (drain_req_cnt != drain_done_cnt) begin
                    bus.i_SENDHARQ_Data_Comp = 1'b1;
                    drain_done_cnt++;
                end
            end
        end
    end

    // driver tasks
    task automatic start_slot(input logic [7:0] mask, input logic [47:0] cbn);
        @(negedge clk);
        bus.i_users_valid_mask = mask;
        bus.i_users_cb_num     = cbn;
        bus.i_rdm_slot_start   = 1'b1;
        @(negedge clk);
        bus.i_rdm_slot_start   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.o_slot_done) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_reqs(input string name, input int target, input int budget);
        for (int i = 0; i < budget && req_cnt < target; i++) @(negedge clk);
        check(name, 32'(req_cnt), 32'(target));
    endtask

    function automatic logic [47:0] cbn_of(input int u0, input int u2);
        logic [47:0] v;
        v = '0;
        v[0 +: 6]  = 6'(u0);
        v[12 +: 6] = 6'(u2);
        return v;
    endfunction

    initial begin
        int r0;
        rstn       = 1'b0;
        comp_en    = 1'b1;
        auto_drain = 1'b1;
        bus.i_rdm_slot_start   = 1'b0;
        bus.i_users_valid_mask = '0;
        bus.i_users_cb_num     = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_request", 32'(bus.o_Combine_process_request), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_slot_done), 32'd0);
        check("rst_total", 32'(bus.o_cb_total), 32'd0);
        check("rst_err", 32'(bus.o_err_flags), 32'd0);
        check("rst_idx", 32'({bus.o_Combine_user_index, bus.o_Combine_cb_index}), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // two users, immediate drain
        exp_q.push_back({4'd0, 6'd0});
        exp_q.push_back({4'd0, 6'd1});
        exp_q.push_back({4'd2, 6'd0});
        start_slot(8'h05, cbn_of(2, 1));
        check("t1_busy", 32'(bus.o_busy), 32'd1);
        wait_done("t1_done", 200);
        check("t1_total", 32'(bus.o_cb_total), 32'd3);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("t1_busy_after", 32'(bus.o_busy), 32'd0);
        check("t1_err", 32'(bus.o_err_flags), 32'd0);

        // empty slot
        r0 = req_cnt;
        start_slot(8'h00, cbn_of(3, 3));
        check("t2_busy_c1", 32'({bus.o_busy, bus.o_slot_done}), 32'b10);
        @(negedge clk);
        check("t2_busy_done_c2", 32'({bus.o_busy, bus.o_slot_done}), 32'b11);
        @(negedge clk);
        check("t2_idle_c3", 32'({bus.o_busy, bus.o_slot_done}), 32'b00);
        check("t2_no_request", 32'(req_cnt), 32'(r0));

        // credit stall with no drains
        auto_drain = 1'b0;
        r0 = req_cnt;
        for (int c = 0; c < 4; c++) exp_q.push_back({4'd0, 6'(c)});
        start_slot(8'h01, cbn_of(4, 0));
        repeat (40) @(negedge clk);
        check("t3_two_reqs", 32'(req_cnt), 32'(r0 + 2));
        check("t3_stall_state", 32'(bus.o_state_dbg), 32'(ST_CREDIT));
        drain_req_cnt++;
        wait_reqs("t3_third_req", r0 + 3, 40);
        drain_req_cnt++;
        wait_done("t3_done", 80);
        check("t3_total", 32'(bus.o_cb_total), 32'd4);
        drain_req_cnt += 2;
        repeat (4) @(negedge clk);
        check("t3_err", 32'(bus.o_err_flags), 32'd0);

        // watchdog timeout
        auto_drain = 1'b1;
        comp_en    = 1'b0;
        exp_q.push_back({4'd0, 6'd0});
        start_slot(8'h01, cbn_of(3, 0));
        wait_done("t4_done", (1 << TO_W) + 50);
        check("t4_err_timeout", 32'(bus.o_err_flags), 32'b001);
        check("t4_total", 32'(bus.o_cb_total), 32'd0);
        @(negedge clk);
        check("t4_busy_after", 32'(bus.o_busy), 32'd0);

        // overrun, then credit overflow
        comp_en = 1'b1;
        exp_q.push_back({4'd0, 6'd0});
        exp_q.push_back({4'd0, 6'd1});
        exp_q.push_back({4'd2, 6'd0});
        start_slot(8'h05, cbn_of(2, 1));
        repeat (5) @(negedge clk);
        start_slot(8'hFF, {8{6'd1}});
        wait_done("t5_done", 200);
        check("t5_total", 32'(bus.o_cb_total), 32'd3);
        check("t5_err_overrun", 32'(bus.o_err_flags), 32'b011);
        drain_req_cnt++;
        repeat (3) @(negedge clk);
        check("t5_err_credit_ovf", 32'(bus.o_err_flags), 32'b111);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // async reset in WAIT_COMP, then full slot on restored credit
        auto_drain = 1'b0;
        r0 = req_cnt;
        exp_q.push_back({4'd0, 6'd0});
        start_slot(8'h01, cbn_of(2, 0));
        wait_reqs("t6_first_req", r0 + 1, 20);
        @(negedge clk);
        check("t6_in_wait_comp", 32'(bus.o_state_dbg), 32'(ST_WAIT_COMP));
        rstn = 1'b0;
        #1;
        check("t6_rst_outputs", 32'({bus.o_busy, bus.o_slot_done, bus.o_Combine_process_request, bus.o_err_flags}), 32'd0);
        check("t6_rst_state", 32'(bus.o_state_dbg), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        exp_q.push_back({4'd0, 6'd0});
        exp_q.push_back({4'd0, 6'd1});
        start_slot(8'h01, cbn_of(2, 0));
        wait_done("t6_done", 100);
        check("t6_total", 32'(bus.o_cb_total), 32'd2);
        check("t6_err", 32'(bus.o_err_flags), 32'd0);
        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
